hamming_channel_injector: RTL and testbench

// - Channel-model stage between the Hamming(8,4) encoder output and the decoder input.
// - Accepts 8-bit codewords on a valid/ready stream and emits each one with a controlled bit-flip mask applied.
// - Injection modes: none, fixed single-bit, fixed double-bit, or LFSR-driven random single-bit.
// - Counts injected words, so the decoder's syndrome/error flags can be checked against a known fault.

---
 rtl/hamming_pkg.sv | 21 ++
 rtl/hamming_lfsr16.sv | 26 ++
 rtl/hamming_channel_injector.sv | 118 +++++++++++
 tb/tb_hamming_channel_injector.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/hamming_pkg.sv
// rtl/hamming_pkg.sv - shared constants and helpers for the Hamming channel injector
package hamming_pkg;

    localparam logic [1:0]  MODE_PASS   = 2'd0;
    localparam logic [1:0]  MODE_SINGLE = 2'd1;
    localparam logic [1:0]  MODE_DOUBLE = 2'd2;
    localparam logic [1:0]  MODE_RANDOM = 2'd3;

    // Taps 16,14,13,11 expressed as bit positions 15,13,12,10
    localparam logic [15:0] LFSR_TAPS         = 16'hB400;
    localparam logic [15:0] LFSR_SEED_DEFAULT = 16'hACE1;

    function automatic logic [15:0] lfsr_step(input logic [15:0] q);
        return {q[14:0], ^(q & LFSR_TAPS)};
    endfunction

    function automatic logic [7:0] bit_mask(input logic [2:0] pos);
        return 8'd1 << pos;
    endfunction

endpackage

// File: rtl/hamming_lfsr16.sv
// rtl/hamming_lfsr16.sv - 16-bit Fibonacci LFSR with seed load and zero-seed substitution
module hamming_lfsr16
    import hamming_pkg::*;
#(
    parameter logic [15:0] SEED = LFSR_SEED_DEFAULT
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    input  logic        load,
    input  logic [15:0] seed,
    output logic [15:0] q
);

    // A zero state would lock the register, so a zero seed falls back to SEED
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q <= SEED;
        end else if (load) begin
            q <= (seed == 16'h0000) ? SEED : seed;
        end else if (adv) begin
            q <= lfsr_step(q);
        end
    end

endmodule

// File: rtl/hamming_channel_injector.sv
// rtl/hamming_channel_injector.sv - applies a controlled bit-flip mask to Hamming(8,4) codewords
module hamming_channel_injector
    import hamming_pkg::*;
#(
    parameter logic [15:0] SEED_DEFAULT = LFSR_SEED_DEFAULT,
    parameter int unsigned CNT_W        = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [1:0]       cfg_mode,
    input  logic [2:0]       cfg_bit_a,
    input  logic [2:0]       cfg_bit_b,
    input  logic [3:0]       cfg_rate,
    input  logic             seed_load,
    input  logic [15:0]      seed,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_code,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [7:0]       out_code,
    output logic [7:0]       out_err_mask,
    input  logic             clr_count,
    output logic [CNT_W-1:0] inj_count
);

    localparam logic [0:0] ST_EMPTY = 1'b0;
    localparam logic [0:0] ST_FULL  = 1'b1;

    logic [0:0]       state_q;
    logic [0:0]       state_d;
    logic             accept;
    logic [15:0]      lfsr_q;
    logic             lfsr_unused;
    logic             rnd_hit;
    logic [7:0]       mask;
    logic [CNT_W-1:0] cnt_q;

    assign out_valid = (state_q == ST_FULL);
    assign in_ready  = !out_valid || out_ready;
    assign accept    = in_valid && in_ready;
    assign inj_count = cnt_q;

    hamming_lfsr16 #(
        .SEED (SEED_DEFAULT)
    ) u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (accept),
        .load  (seed_load),
        .seed  (seed),
        .q     (lfsr_q)
    );

    assign lfsr_unused = ^lfsr_q[15:7];

    // Rate 15 must always hit, but lfsr[3:0] < 15 misses when the nibble is 15
    assign rnd_hit = (cfg_rate == 4'hF) || (lfsr_q[3:0] < cfg_rate);

    always_comb begin
        mask = 8'h00;
        case (cfg_mode)
            MODE_SINGLE: mask = bit_mask(cfg_bit_a);
            MODE_DOUBLE: begin
                if (cfg_bit_a == cfg_bit_b) begin
                    mask = bit_mask(cfg_bit_a) | bit_mask(cfg_bit_a + 3'd1);
                end else begin
                    mask = bit_mask(cfg_bit_a) | bit_mask(cfg_bit_b);
                end
            end
            MODE_RANDOM: begin
                if (rnd_hit) begin
                    mask = bit_mask(lfsr_q[6:4]);
                end
            end
            default: mask = 8'h00;
        endcase
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_EMPTY: if (in_valid) state_d = ST_FULL;
            ST_FULL:  if (out_ready && !in_valid) state_d = ST_EMPTY;
            default:  state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_EMPTY;
        end else begin
            state_q <= state_d;
        end
    end

    // Data registers only load on accept, so a stalled word and late config edits cannot disturb it
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_code     <= 8'h00;
            out_err_mask <= 8'h00;
        end else if (accept) begin
            out_code     <= in_code ^ mask;
            out_err_mask <= mask;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (clr_count) begin
            cnt_q <= '0;
        end else if (accept && (mask != 8'h00) && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

endmodule

// File: tb/tb_hamming_channel_injector.sv
// tb/tb_hamming_channel_injector.sv - self-checking bench for hamming_channel_injector
module tb_hamming_channel_injector;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [1:0]  cfg_mode;
    logic [2:0]  cfg_bit_a;
    logic [2:0]  cfg_bit_b;
    logic [3:0]  cfg_rate;
    logic        seed_load;
    logic [15:0] seed;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  in_code;
    logic        out_valid;
    logic        out_ready;
    logic [7:0]  out_code;
    logic [7:0]  out_err_mask;
    logic        clr_count;
    logic [15:0] inj_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [7:0]  s_out_code;
    logic [7:0]  s_out_err_mask;
    logic [3:0]  sat_count;

    int n_checks = 0;
    int n_fail   = 0;

    bit          m_full;
    logic [7:0]  m_code;
    logic [7:0]  m_mask;
    logic [15:0] m_lfsr;
    int          m_cnt;
    int          m_sat;

    always #5 clk = ~clk;

    hamming_channel_injector dut (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_bit_a(cfg_bit_a),
        .cfg_bit_b(cfg_bit_b), .cfg_rate(cfg_rate), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(in_ready), .in_code(in_code),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_err_mask(out_err_mask), .clr_count(clr_count), .inj_count(inj_count)
    );

    hamming_channel_injector #(.CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .cfg_mode(cfg_mode), .cfg_bit_a(cfg_bit_a),
        .cfg_bit_b(cfg_bit_b), .cfg_rate(cfg_rate), .seed_load(seed_load), .seed(seed),
        .in_valid(in_valid), .in_ready(s_in_ready), .in_code(in_code),
        .out_valid(s_out_valid), .out_ready(out_ready), .out_code(s_out_code),
        .out_err_mask(s_out_err_mask), .clr_count(clr_count), .inj_count(sat_count)
    );

    function automatic logic [15:0] ref_next(input logic [15:0] q);
        return {q[14:0], q[15] ^ q[13] ^ q[12] ^ q[10]};
    endfunction

    function automatic logic [7:0] ref_mask(input int mode, input int a, input int b,
                                            input int rate, input int l);
        int m;
        case (mode)
            0: m = 0;
            1: m = 1 << a;
            2: m = (a == b) ? ((1 << a) | (1 << ((a + 1) % 8))) : ((1 << a) | (1 << b));
            default: m = ((rate == 15) || ((l % 16) < rate)) ? (1 << ((l / 16) % 8)) : 0;
        endcase
        return m[7:0];
    endfunction

    task automatic model_reset();
        m_full = 0; m_code = 8'h00; m_mask = 8'h00;
        m_lfsr = 16'hACE1; m_cnt = 0; m_sat = 0;
    endtask

    // Advance the reference by one clock using the currently driven inputs, then step the DUT.
    task automatic tick();
        bit         acc;
        logic [7:0] mk;
        acc = in_valid && (!m_full || out_ready);
        mk  = ref_mask(int'(cfg_mode), int'(cfg_bit_a), int'(cfg_bit_b), int'(cfg_rate), int'(m_lfsr));
        if (acc) begin
            m_full = 1; m_code = in_code ^ mk; m_mask = mk;
        end else if (out_ready) begin
            m_full = 0;
        end
        if (seed_load) m_lfsr = (seed == 16'h0) ? 16'hACE1 : seed;
        else if (acc)  m_lfsr = ref_next(m_lfsr);
        if (clr_count) begin
            m_cnt = 0; m_sat = 0;
        end else if (acc && mk != 8'h00) begin
            if (m_cnt < 65535) m_cnt++;
            if (m_sat < 15) m_sat++;
        end
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input logic [1:0] md, input logic [2:0] a, input logic [2:0] b,
                           input logic [3:0] r);
        cfg_mode = md; cfg_bit_a = a; cfg_bit_b = b; cfg_rate = r;
    endtask

    task automatic test_reset();
        rst_n = 0; set_cfg(2'd0, 3'd0, 3'd0, 4'd0);
        seed_load = 0; seed = 16'h0; in_valid = 0; in_code = 8'h00;
        out_ready = 1; clr_count = 0;
        model_reset();
        @(posedge clk); @(posedge clk); #1;
        n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL reset_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_code !== 8'h00)   begin n_fail++; $display("FAIL reset_code: got %h expected 00", out_code); end
        n_checks++; if (out_err_mask !== 8'h00) begin n_fail++; $display("FAIL reset_mask: got %h expected 00", out_err_mask); end
        n_checks++; if (inj_count !== 16'h0)  begin n_fail++; $display("FAIL reset_count: got %h expected 0000", inj_count); end
        n_checks++; if (in_ready !== 1'b1)    begin n_fail++; $display("FAIL reset_ready: got %b expected 1", in_ready); end
        rst_n = 1;
        tick();
    endtask

    task automatic test_pass();
        set_cfg(2'd0, 3'd0, 3'd0, 4'd0);
        in_valid = 1; in_code = 8'hA5; out_ready = 1;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL pass_pre_valid: got %b expected 0", out_valid); end
        tick();
        in_valid = 0;
        n_checks++; if (out_valid !== 1'b1)   begin n_fail++; $display("FAIL pass_valid: got %b expected 1", out_valid); end
        n_checks++; if (out_code !== 8'hA5)   begin n_fail++; $display("FAIL pass_code: got %h expected a5", out_code); end
        n_checks++; if (out_err_mask !== 8'h00) begin n_fail++; $display("FAIL pass_mask: got %h expected 00", out_err_mask); end
        n_checks++; if (inj_count !== 16'd0)  begin n_fail++; $display("FAIL pass_count: got %0d expected 0", inj_count); end
        tick();
        n_checks++; if (out_valid !== 1'b0)   begin n_fail++; $display("FAIL pass_drain: got %b expected 0", out_valid); end
    endtask

    task automatic test_single();
        set_cfg(2'd1, 3'd2, 3'd0, 4'd0);
        in_valid = 1; in_code = 8'h5A;
        tick();
        in_valid = 0;
        n_checks++; if (out_code !== 8'h5E)   begin n_fail++; $display("FAIL single_code: got %h expected 5e", out_code); end
        n_checks++; if (out_err_mask !== 8'h04) begin n_fail++; $display("FAIL single_mask: got %h expected 04", out_err_mask); end
        n_checks++; if (inj_count !== 16'd1)  begin n_fail++; $display("FAIL single_count: got %0d expected 1", inj_count); end
        tick();
    endtask

    task automatic test_double();
        logic [2:0]  a_tab [3] = '{3'd0, 3'd3, 3'd7};
        logic [2:0]  b_tab [3] = '{3'd7, 3'd3, 3'd7};
        logic [7:0]  e_tab [3] = '{8'h81, 8'h18, 8'h81};
        in_code = 8'h00; in_valid = 1;
        for (int i = 0; i < 3; i++) begin
            set_cfg(2'd2, a_tab[i], b_tab[i], 4'd0);
            tick();
            n_checks++; if (out_code !== e_tab[i]) begin n_fail++; $display("FAIL double_code[%0d]: got %h expected %h", i, out_code, e_tab[i]); end
        end
        in_valid = 0;
        n_checks++; if (inj_count !== 16'd4) begin n_fail++; $display("FAIL double_count: got %0d expected 4", inj_count); end
        tick();
    endtask

    task automatic test_random_rate();
        int          c_start;
        logic [7:0]  code;
        c_start = m_cnt;
        set_cfg(2'd3, 3'd0, 3'd0, 4'd0);
        in_valid = 1;
        for (int i = 0; i < 100; i++) begin
            code = 8'($urandom); in_code = code;
            tick();
            n_checks++; if (out_err_mask !== 8'h00 || out_code !== code) begin n_fail++; $display("FAIL rate0_word[%0d]: got %h/%h expected %h/00", i, out_code, out_err_mask, code); end
        end
        n_checks++; if (inj_count !== 16'(c_start)) begin n_fail++; $display("FAIL rate0_count: got %0d expected %0d", inj_count, c_start); end
        cfg_rate = 4'd15;
        for (int i = 0; i < 100; i++) begin
            code = 8'($urandom); in_code = code;
            tick();
            n_checks++; if (out_err_mask !== m_mask || $countones(out_err_mask) != 1 || out_code !== (code ^ m_mask))
                begin n_fail++; $display("FAIL rate15_word[%0d]: got %h/%h expected %h/%h", i, out_code, out_err_mask, code ^ m_mask, m_mask); end
        end
        in_valid = 0;
        n_checks++; if (inj_count !== 16'(c_start + 100)) begin n_fail++; $display("FAIL rate15_count: got %0d expected %0d", inj_count, c_start + 100); end
        tick();
    endtask

    task automatic test_backpressure();
        set_cfg(2'd1, 3'd1, 3'd0, 4'd0);
        in_valid = 1; in_code = 8'h11; out_ready = 1;
        tick();
        out_ready = 0; in_code = 8'h22;
        for (int i = 0; i < 5; i++) begin
            #1;
            n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_ready[%0d]: got %b expected 0", i, in_ready); end
            n_checks++; if (out_valid !== 1'b1 || out_code !== 8'h13) begin n_fail++; $display("FAIL bp_hold[%0d]: got %b/%h expected 1/13", i, out_valid, out_code); end
            cfg_bit_a = 3'(i + 3);
            tick();
        end
        out_ready = 1; cfg_bit_a = 3'd1;
        for (int i = 0; i < 4; i++) begin
            in_code = 8'(8'h22 + 8'(i * 17));
            tick();
            n_checks++; if (out_valid !== 1'b1 || out_code !== (8'(8'h22 + 8'(i * 17)) ^ 8'h02))
                begin n_fail++; $display("FAIL bp_b2b[%0d]: got %b/%h expected 1/%h", i, out_valid, out_code, 8'(8'h22 + 8'(i * 17)) ^ 8'h02); end
        end
        in_valid = 0;
        tick();
    endtask

    task automatic test_seed();
        logic [7:0] exp_tab [3] = '{8'h40, 8'h10, 8'h08};
        seed_load = 1; seed = 16'h0000; in_valid = 0;
        tick();
        seed_load = 0;
        set_cfg(2'd3, 3'd0, 3'd0, 4'd15);
        in_valid = 1; in_code = 8'h00;
        for (int i = 0; i < 3; i++) begin
            seed_load = (i == 1); seed = 16'h1234;
            tick();
            n_checks++; if (out_err_mask !== exp_tab[i]) begin n_fail++; $display("FAIL seed_mask[%0d]: got %h expected %h", i, out_err_mask, exp_tab[i]); end
        end
        seed_load = 0; in_valid = 0;
        tick();
    endtask

    task automatic test_clr();
        set_cfg(2'd1, 3'd0, 3'd0, 4'd0);
        in_valid = 1; in_code = 8'h00; clr_count = 1;
        tick();
        clr_count = 0;
        n_checks++; if (inj_count !== 16'd0 || out_code !== 8'h01) begin n_fail++; $display("FAIL clr_wins: got %0d/%h expected 0/01", inj_count, out_code); end
        tick();
        in_valid = 0;
        n_checks++; if (inj_count !== 16'd1) begin n_fail++; $display("FAIL clr_after: got %0d expected 1", inj_count); end
        tick();
    endtask

    task automatic test_saturation();
        clr_count = 1; in_valid = 0;
        tick();
        clr_count = 0;
        set_cfg(2'd1, 3'd5, 3'd0, 4'd0);
        in_valid = 1;
        for (int i = 1; i <= 20; i++) begin
            in_code = 8'($urandom);
            tick();
            n_checks++; if (sat_count !== 4'(m_sat)) begin n_fail++; $display("FAIL sat_step[%0d]: got %0d expected %0d", i, sat_count, m_sat); end
        end
        in_valid = 0;
        n_checks++; if (sat_count !== 4'hF) begin n_fail++; $display("FAIL sat_final: got %h expected f", sat_count); end
        n_checks++; if (inj_count !== 16'd20) begin n_fail++; $display("FAIL sat_wide: got %0d expected 20", inj_count); end
        tick();
    endtask

    task automatic test_stream_random();
        for (int i = 0; i < 400; i++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 3) != 0);
            in_code   = 8'($urandom);
            set_cfg(2'($urandom), 3'($urandom), 3'($urandom), 4'($urandom));
            clr_count = ($urandom_range(0, 15) == 0);
            seed_load = ($urandom_range(0, 31) == 0);
            seed      = ($urandom_range(0, 1) == 0) ? 16'h0000 : 16'($urandom);
            #1;
            n_checks++; if (in_ready !== (!m_full || out_ready)) begin n_fail++; $display("FAIL rnd_ready[%0d]: got %b expected %b", i, in_ready, !m_full || out_ready); end
            n_checks++; if (out_valid !== m_full) begin n_fail++; $display("FAIL rnd_valid[%0d]: got %b expected %b", i, out_valid, m_full); end
            if (m_full) begin
                n_checks++; if (out_code !== m_code || out_err_mask !== m_mask) begin n_fail++; $display("FAIL rnd_data[%0d]: got %h/%h expected %h/%h", i, out_code, out_err_mask, m_code, m_mask); end
            end
            n_checks++; if (inj_count !== 16'(m_cnt) || sat_count !== 4'(m_sat)) begin n_fail++; $display("FAIL rnd_count[%0d]: got %0d/%0d expected %0d/%0d", i, inj_count, sat_count, m_cnt, m_sat); end
            tick();
        end
        in_valid = 0; out_ready = 1; clr_count = 0; seed_load = 0;
        tick();
    endtask

    task automatic test_reset_mid();
        set_cfg(2'd1, 3'd3, 3'd0, 4'd0);
        in_valid = 1; in_code = 8'h77; out_ready = 1;
        tick();
        out_ready = 0; in_valid = 0;
        #1;
        rst_n = 0;
        #1;
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_valid: got %b expected 0", out_valid); end
        n_checks++; if (out_code !== 8'h00 || inj_count !== 16'd0) begin n_fail++; $display("FAIL rst_mid_state: got %h/%0d expected 00/0", out_code, inj_count); end
        model_reset();
        @(posedge clk); #1;
        rst_n = 1; out_ready = 1;
        tick();
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rst_mid_after: got %b expected 0", out_valid); end
    endtask

    initial begin
        test_reset();
        test_pass();
        test_single();
        test_double();
        test_random_rate();
        test_backpressure();
        test_seed();
        test_clr();
        test_saturation();
        test_stream_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
